uart_rx_frame: RTL

- UART receiver; the receive-side counterpart of the team's UART TX path.
- Oversamples RX_IN at Prescale clocks per bit and majority-votes each bit.
- Assembles start, data (LSB first), optional parity and stop bits into a parallel word.
- Flags parity and stop errors. Sits between the RX pin and the system's RX data consumer.

---
 rtl/uart_rx_frame.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// UART receiver: oversampled 3-sample majority vote, LSB-first data, optional parity, stop check.
// Optional `define UART_RX_SYNC_EN adds a 2-flop RX_IN synchronizer (+2 cycles of latency).
module uart_rx_frame #(
  parameter int Data_WD     = 8,
  parameter int PRESCALE_WD = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESCALE_WD-1:0] Prescale,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  output logic [Data_WD-1:0]     P_DATA,
  output logic                   Data_Valid,
  output logic                   Par_Err,
  output logic                   Stp_Err
);

  localparam int BW = $clog2(Data_WD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [PRESCALE_WD-1:0] ec_q, ec_d;
  logic [PRESCALE_WD-1:0] p_q, p_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]             samp_q, samp_d;
  logic                   bit_q, bit_d;
  logic [Data_WD-1:0]     shift_q, shift_d;
  logic [Data_WD-1:0]     p_data_q, p_data_d;
  logic                   par_en_q, par_en_d;
  logic                   par_typ_q, par_typ_d;
  logic                   par_fail_q, par_fail_d;
  logic                   dv_q, dv_d;
  logic                   pe_q, pe_d;
  logic                   se_q, se_d;

  logic                   rx_line;
  logic [PRESCALE_WD-1:0] p_clamped;
  logic [PRESCALE_WD-1:0] half;
  logic [PRESCALE_WD-1:0] p_last;
  logic                   bit_end;
  logic                   vote_now;
  logic                   vote;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end

  assign rx_line = sync_q[1];
`else
  assign rx_line = RX_IN;
`endif

  // Force the bit period even and at least 8 so the H-1..H+2 window fits inside it.
  always_comb begin
    p_clamped = {Prescale[PRESCALE_WD-1:1], 1'b0};
    if (Prescale < PRESCALE_WD'(8)) begin
      p_clamped = PRESCALE_WD'(8);
    end
  end

  assign half     = p_q >> 1;
  assign p_last   = p_q - PRESCALE_WD'(1);
  assign bit_end  = (ec_q == p_last);
  assign vote_now = (ec_q == half + PRESCALE_WD'(2));
  assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ec_d       = ec_q;
    p_d        = p_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_fail_d = par_fail_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q != IDLE) begin
      ec_d = bit_end ? '0 : ec_q + PRESCALE_WD'(1);
      if (ec_q == half - PRESCALE_WD'(1)) samp_d[0] = rx_line;
      if (ec_q == half)                   samp_d[1] = rx_line;
      if (ec_q == half + PRESCALE_WD'(1)) samp_d[2] = rx_line;
      if (vote_now)                       bit_d     = vote;
    end

    case (state_q)
      IDLE: begin
        ec_d = '0;
        // The cycle the low line is seen counts as ec=0 of the start bit.
        if (!rx_line) begin
          state_d    = START;
          ec_d       = PRESCALE_WD'(1);
          p_d        = p_clamped;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (vote_now && vote) begin
          state_d = IDLE;
          ec_d    = '0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (vote_now) begin
          shift_d = {vote, shift_q[Data_WD-1:1]};
        end
        if (bit_end) begin
          if (bit_cnt_q == BW'(Data_WD - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (vote_now) begin
          par_fail_d = (((^shift_q) ^ vote) != par_typ_q);
        end
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          pe_d    = par_fail_q;
          se_d    = ~bit_q;
          dv_d    = ~par_fail_q & bit_q;
          if (~par_fail_q & bit_q) begin
            p_data_d = shift_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ec_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ec_q       <= '0;
      p_q        <= PRESCALE_WD'(8);
      bit_cnt_q  <= '0;
      samp_q     <= 3'b111;
      bit_q      <= 1'b1;
      shift_q    <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail_q <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      ec_q       <= ec_d;
      p_q        <= p_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_fail_q <= par_fail_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign Par_Err    = pe_q;
  assign Stp_Err    = se_q;

endmodule
